// File: rtl/svm_order_pkg.sv
// svm_order_pkg: shared encodings for the SVM order generator.
// Position states, order side/quantity codes and the order payload struct.
package svm_order_pkg;

    typedef enum logic [1:0] {
        POS_FLAT  = 2'b00,
        POS_LONG  = 2'b01,
        POS_SHORT = 2'b10
    } pos_state_e;

    localparam int QTY_WIDTH = 2;

    localparam logic SIDE_BUY  = 1'b1;
    localparam logic SIDE_SELL = 1'b0;

    localparam logic [QTY_WIDTH-1:0] QTY_SINGLE  = 2'd1;
    localparam logic [QTY_WIDTH-1:0] QTY_REVERSE = 2'd2;

    // Two's-complement position values reported alongside the state.
    localparam logic [1:0] POSITION_FLAT  = 2'b00;
    localparam logic [1:0] POSITION_LONG  = 2'b01;
    localparam logic [1:0] POSITION_SHORT = 2'b11;

    typedef struct packed {
        logic                 side;
        logic [QTY_WIDTH-1:0] qty;
    } order_t;

    // Maps a position state to its signed -1/0/+1 value.
    function automatic logic [1:0] positionOf(input pos_state_e state);
        case (state)
            POS_LONG:  return POSITION_LONG;
            POS_SHORT: return POSITION_SHORT;
            default:   return POSITION_FLAT;
        endcase
    endfunction

endpackage

// File: rtl/svm_order_gen_if.sv
// svm_order_gen_if: valid/ready order bus toward the order-entry/risk stage.
// The master drives the order, the slave returns ready.
interface svm_order_gen_if;
    import svm_order_pkg::*;

    logic                 order_valid;
    logic                 order_ready;
    logic                 order_side;
    logic [QTY_WIDTH-1:0] order_qty;

    modport master (
        output order_valid,
        output order_side,
        output order_qty,
        input  order_ready
    );

    modport slave (
        input  order_valid,
        input  order_side,
        input  order_qty,
        output order_ready
    );

endinterface

// File: rtl/svm_order_slot.sv
// svm_order_slot: one-entry valid/ready holding register for {side, qty}.
// A load while the current order is being accepted refills the slot with no
// bubble; the caller only loads when free_o is high.
module svm_order_slot
    import svm_order_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load_i,
    input  order_t order_i,
    output logic   free_o,
    svm_order_gen_if.master bus
);

    logic   valid_q, valid_d;
    order_t order_q, order_d;

    assign free_o = !valid_q || bus.order_ready;

    // Next-state: load wins, otherwise an accepted order empties the slot.
    always_comb begin
        valid_d = valid_q;
        order_d = order_q;
        if (load_i) begin
            valid_d = 1'b1;
            order_d = order_i;
        end else if (valid_q && bus.order_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot register; reset drops any pending order without a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            order_q <= '0;
        end else begin
            valid_q <= valid_d;
            order_q <= order_d;
        end
    end

    assign bus.order_valid = valid_q;
    assign bus.order_side  = order_q.side;
    assign bus.order_qty   = order_q.qty;

endmodule

// File: rtl/svm_order_gen.sv
// svm_order_gen: turns SVM decision samples into trade orders.
// Hysteresis thresholds pick the order, a FLAT/LONG/SHORT state machine
// tracks position, a cooldown rate-limits trading and enable=0 flattens.
// Optional macro SVM_PRED_CHECK_EN: drop samples whose prediction bit
// disagrees with the sign of the decision value.
module svm_order_gen
    import svm_order_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int COOLDOWN_CYCLES = 32,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         svm_valid,
    input  logic signed [DATA_WIDTH-1:0] svm_decision,
    input  logic                         svm_pred,
    input  logic        [DATA_WIDTH-2:0] thresh_enter,
    input  logic        [DATA_WIDTH-2:0] thresh_exit,
    input  logic                         enable,
    svm_order_gen_if.master              orderBus,
    output logic        [1:0]            position,
    output logic        [1:0]            pos_state,
    output logic        [CNT_WIDTH-1:0]  drop_count
);

    localparam logic [CNT_WIDTH-1:0] COOLDOWN_LOAD = CNT_WIDTH'(COOLDOWN_CYCLES);

    pos_state_e           posState_q, posState_d;
    logic [1:0]           position_q;
    logic [CNT_WIDTH-1:0] cooldown_q, cooldown_d;
    logic [CNT_WIDTH-1:0] dropCount_q, dropCount_d;

    logic   slotFree;
    logic   genOrder;
    order_t genPayload;

    // One extra bit keeps negated thresholds and extreme decisions exact.
    logic signed [DATA_WIDTH:0] decisionExt;
    logic signed [DATA_WIDTH:0] enterPos, enterNeg, exitPos, exitNeg;
    logic geEnter, leNegEnter, ltExit, gtNegExit;

    logic predConsistent;
    logic eligible;
    logic killFlatten;
    logic sampleTaken;
    logic dropEvent;

    assign decisionExt = {svm_decision[DATA_WIDTH-1], svm_decision};
    assign enterPos    = {2'b00, thresh_enter};
    assign exitPos     = {2'b00, thresh_exit};
    assign enterNeg    = -enterPos;
    assign exitNeg     = -exitPos;

    assign geEnter    = decisionExt >= enterPos;
    assign leNegEnter = decisionExt <= enterNeg;
    assign ltExit     = decisionExt <  exitPos;
    assign gtNegExit  = decisionExt >  exitNeg;

`ifdef SVM_PRED_CHECK_EN
    assign predConsistent = (svm_pred == !svm_decision[DATA_WIDTH-1]);
`else
    logic unusedPred;
    assign unusedPred     = svm_pred;
    assign predConsistent = 1'b1;
`endif

    assign eligible    = slotFree && (cooldown_q == '0) && enable;
    assign killFlatten = !enable && (posState_q != POS_FLAT) && slotFree;
    assign sampleTaken = svm_valid && eligible && predConsistent;
    assign dropEvent   = svm_valid && !(eligible && predConsistent);

    // Order selection: kill-switch flatten first, then the hysteresis table.
    always_comb begin
        posState_d      = posState_q;
        genOrder        = 1'b0;
        genPayload.side = SIDE_SELL;
        genPayload.qty  = QTY_SINGLE;
        if (killFlatten) begin
            genOrder        = 1'b1;
            genPayload.side = (posState_q == POS_LONG) ? SIDE_SELL : SIDE_BUY;
            genPayload.qty  = QTY_SINGLE;
            posState_d      = POS_FLAT;
        end else if (sampleTaken) begin
            case (posState_q)
                POS_FLAT: begin
                    if (geEnter) begin
                        genOrder        = 1'b1;
                        genPayload.side = SIDE_BUY;
                        posState_d      = POS_LONG;
                    end else if (leNegEnter) begin
                        genOrder        = 1'b1;
                        genPayload.side = SIDE_SELL;
                        posState_d      = POS_SHORT;
                    end
                end
                POS_LONG: begin
                    if (leNegEnter) begin
                        genOrder        = 1'b1;
                        genPayload.side = SIDE_SELL;
                        genPayload.qty  = QTY_REVERSE;
                        posState_d      = POS_SHORT;
                    end else if (ltExit) begin
                        genOrder        = 1'b1;
                        genPayload.side = SIDE_SELL;
                        posState_d      = POS_FLAT;
                    end
                end
                POS_SHORT: begin
                    if (geEnter) begin
                        genOrder        = 1'b1;
                        genPayload.side = SIDE_BUY;
                        genPayload.qty  = QTY_REVERSE;
                        posState_d      = POS_LONG;
                    end else if (gtNegExit) begin
                        genOrder        = 1'b1;
                        genPayload.side = SIDE_BUY;
                        posState_d      = POS_FLAT;
                    end
                end
                default: posState_d = POS_FLAT;
            endcase
        end
    end

    // Cooldown reloads on every generated order and otherwise counts down.
    always_comb begin
        cooldown_d = cooldown_q;
        if (genOrder) begin
            cooldown_d = COOLDOWN_LOAD;
        end else if (cooldown_q != '0) begin
            cooldown_d = cooldown_q - CNT_WIDTH'(1);
        end
    end

    // Ignored samples are counted, saturating at all-ones.
    always_comb begin
        dropCount_d = dropCount_q;
        if (dropEvent && (dropCount_q != '1)) begin
            dropCount_d = dropCount_q + CNT_WIDTH'(1);
        end
    end

    // Position state machine; position updates optimistically at generation.
    always_ff @(posedge clk) begin
        if (rst) begin
            posState_q <= POS_FLAT;
            position_q <= POSITION_FLAT;
        end else begin
            posState_q <= posState_d;
            position_q <= positionOf(posState_d);
        end
    end

    // Cooldown and drop counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cooldown_q  <= '0;
            dropCount_q <= '0;
        end else begin
            cooldown_q  <= cooldown_d;
            dropCount_q <= dropCount_d;
        end
    end

    svm_order_slot u_slot (
        .clk     (clk),
        .rst     (rst),
        .load_i  (genOrder),
        .order_i (genPayload),
        .free_o  (slotFree),
        .bus     (orderBus)
    );

    assign position   = position_q;
    assign pos_state  = posState_q;
    assign drop_count = dropCount_q;

endmodule

// File: tb/tb_svm_order_gen.sv
// tb_svm_order_gen: directed checks of svm_order_gen with enter=0x0080,
// exit=0x0020 and a 4-cycle cooldown.
module tb_svm_order_gen;
    import svm_order_pkg::*;

    localparam int DW = 16;
    localparam int CW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 svm_valid;
    logic signed [DW-1:0] svm_decision;
    logic                 svm_pred;
    logic        [DW-2:0] thresh_enter;
    logic        [DW-2:0] thresh_exit;
    logic                 enable;
    logic        [1:0]    position;
    logic        [1:0]    pos_state;
    logic        [CW-1:0] drop_count;

    int compareCount  = 0;
    int mismatchCount = 0;

    svm_order_gen_if orderBus ();

    svm_order_gen #(
        .DATA_WIDTH      (DW),
        .COOLDOWN_CYCLES (4),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .svm_valid    (svm_valid),
        .svm_decision (svm_decision),
        .svm_pred     (svm_pred),
        .thresh_enter (thresh_enter),
        .thresh_exit  (thresh_exit),
        .enable       (enable),
        .orderBus     (orderBus),
        .position     (position),
        .pos_state    (pos_state),
        .drop_count   (drop_count)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One-cycle decision strobe with a prediction bit matching the sign.
    task automatic applyStimulus(input logic [15:0] decision);
        svm_decision = decision;
        svm_pred     = ~decision[15];
        svm_valid    = 1'b1;
        @(negedge clk);
        svm_valid    = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOrder(input string tag, input logic v, input logic s,
                              input logic [1:0] q);
        checkOutput({tag, ".valid"}, 32'(orderBus.order_valid), 32'(v));
        if (v) begin
            checkOutput({tag, ".side"}, 32'(orderBus.order_side), 32'(s));
            checkOutput({tag, ".qty"}, 32'(orderBus.order_qty), 32'(q));
        end
    endtask

    task automatic checkPos(input string tag, input logic [1:0] st, input logic [1:0] pos);
        checkOutput({tag, ".pos_state"}, 32'(pos_state), 32'(st));
        checkOutput({tag, ".position"}, 32'(position), 32'(pos));
    endtask

    initial begin
        rst                  = 1'b1;
        svm_valid            = 1'b0;
        svm_decision         = '0;
        svm_pred             = 1'b0;
        thresh_enter         = 15'h0080;
        thresh_exit          = 15'h0020;
        enable               = 1'b1;
        orderBus.order_ready = 1'b1;

        idleCycles(2);
        checkOrder("reset", 1'b0, 1'b0, 2'd0);
        checkOutput("reset.side", 32'(orderBus.order_side), 32'h0);
        checkOutput("reset.qty", 32'(orderBus.order_qty), 32'h0);
        checkPos("reset", 2'b00, 2'b00);
        checkOutput("reset.drop", 32'(drop_count), 32'd0);
        rst = 1'b0;

        // Entry from FLAT.
        applyStimulus(16'h0100);
        checkOrder("entry", 1'b1, 1'b1, 2'd1);
        checkPos("entry", 2'b01, 2'b01);
        idleCycles(1);
        checkOrder("entryAccepted", 1'b0, 1'b0, 2'd0);
        idleCycles(3);

        // Hysteresis: hold above exit and exactly at exit, leave below it.
        applyStimulus(16'h0040);
        checkOrder("holdAbove", 1'b0, 1'b0, 2'd0);
        checkPos("holdAbove", 2'b01, 2'b01);
        checkOutput("holdAbove.drop", 32'(drop_count), 32'd0);
        applyStimulus(16'h0020);
        checkOrder("holdAtExit", 1'b0, 1'b0, 2'd0);
        checkPos("holdAtExit", 2'b01, 2'b01);
        applyStimulus(16'h0010);
        checkOrder("exitLong", 1'b1, 1'b0, 2'd1);
        checkPos("exitLong", 2'b00, 2'b00);
        idleCycles(4);

        // Entry exactly at +enter.
        applyStimulus(16'h0080);
        checkOrder("entryAtEnter", 1'b1, 1'b1, 2'd1);
        checkPos("entryAtEnter", 2'b01, 2'b01);
        idleCycles(4);

        // Reversal, then samples during cooldown (3 and 1 remaining) are dropped.
        applyStimulus(16'hFF00);
        checkOrder("reversal", 1'b1, 1'b0, 2'd2);
        checkPos("reversal", 2'b10, 2'b11);
        idleCycles(1);
        applyStimulus(16'h0000);
        checkOrder("cooldownDrop", 1'b0, 1'b0, 2'd0);
        checkOutput("cooldownDrop.drop", 32'(drop_count), 32'd1);
        checkPos("cooldownDrop", 2'b10, 2'b11);
        idleCycles(1);
        applyStimulus(16'h0000);
        checkOutput("cooldownLast.drop", 32'(drop_count), 32'd2);
        checkPos("cooldownLast", 2'b10, 2'b11);

        // Cooldown expired: exit SHORT into a stalled downstream.
        orderBus.order_ready = 1'b0;
        applyStimulus(16'h0000);
        checkOrder("exitShort", 1'b1, 1'b1, 2'd1);
        checkPos("exitShort", 2'b00, 2'b00);
        checkOutput("exitShort.drop", 32'(drop_count), 32'd2);

        // Backpressure: three samples dropped, payload held.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'hFF00);
        end
        checkOutput("backpressure.drop", 32'(drop_count), 32'd5);
        checkOrder("backpressure", 1'b1, 1'b1, 2'd1);
        checkPos("backpressure", 2'b00, 2'b00);
        orderBus.order_ready = 1'b1;
        idleCycles(1);
        checkOrder("drain", 1'b0, 1'b0, 2'd0);
        idleCycles(1);
        checkOrder("drainOnce", 1'b0, 1'b0, 2'd0);

        // Kill switch while SHORT with cooldown active; accept and reload together.
        applyStimulus(16'hFF80);
        checkOrder("entryShortAtEnter", 1'b1, 1'b0, 2'd1);
        checkPos("entryShortAtEnter", 2'b10, 2'b11);
        enable = 1'b0;
        idleCycles(1);
        checkOrder("kill", 1'b1, 1'b1, 2'd1);
        checkPos("kill", 2'b00, 2'b00);
        idleCycles(1);
        checkOrder("killFlatIdle", 1'b0, 1'b0, 2'd0);
        applyStimulus(16'h0100);
        checkOrder("disabledSample", 1'b0, 1'b0, 2'd0);
        checkOutput("disabledSample.drop", 32'(drop_count), 32'd6);
        checkPos("disabledSample", 2'b00, 2'b00);

        // Reset with an order stuck pending.
        enable = 1'b1;
        idleCycles(4);
        orderBus.order_ready = 1'b0;
        applyStimulus(16'h0100);
        checkOrder("preReset", 1'b1, 1'b1, 2'd1);
        checkOutput("preReset.drop", 32'(drop_count), 32'd6);
        rst = 1'b1;
        idleCycles(1);
        rst = 1'b0;
        checkOrder("midReset", 1'b0, 1'b0, 2'd0);
        checkOutput("midReset.qty", 32'(orderBus.order_qty), 32'h0);
        checkPos("midReset", 2'b00, 2'b00);
        checkOutput("midReset.drop", 32'(drop_count), 32'd0);

        // Reset also clears the cooldown: the next sample trades immediately.
        applyStimulus(16'h0100);
        checkOrder("postReset", 1'b1, 1'b1, 2'd1);
        checkPos("postReset", 2'b01, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/svm_order_gen.md
Name: svm_order_gen

Overview:
Downstream consumer of the kernel SVM stage: takes its output_valid, decision_value and prediction, and turns the classifier output into trade orders.
- Hysteresis thresholds select the order; a position state machine tracks FLAT/LONG/SHORT.
- A cooldown counter rate-limits trading.
- One-entry valid/ready order register feeds the order-entry/risk stage; an enable kill switch forces flatten.

Parameters:
DATA_WIDTH, 16, width of decision value (signed Q8.8).
COOLDOWN_CYCLES, 32, cycles new samples are ignored after an order is generated (0 = no cooldown).
CNT_WIDTH, 16, width of drop counter and cooldown counter.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
svm_valid  in  1  one-cycle strobe, decision sample present.
svm_decision  in  DATA_WIDTH  signed Q8.8 decision value.
svm_pred  in  1  classifier prediction bit.
thresh_enter  in  DATA_WIDTH-1  unsigned Q8.8 entry magnitude.
thresh_exit  in  DATA_WIDTH-1  unsigned Q8.8 exit magnitude; must be ≤ thresh_enter.
enable  in  1  trading enable; low = kill switch.
order_valid  out  1  order pending.
order_ready  in  1  downstream accepts order.
order_side  out  1  1 = buy, 0 = sell.
order_qty  out  2  quantity: 1 or 2.
position  out  2  signed position: -1, 0 or +1.
pos_state  out  2  FLAT=00, LONG=01, SHORT=10.
drop_count  out  CNT_WIDTH  saturating count of ignored samples.

Behaviour:
- Reset values: all outputs 0, pos_state FLAT, cooldown counter 0. Reset mid-operation discards any pending order with no handshake.
- Comparisons sign-extend both operands to DATA_WIDTH+1 bits. Negated thresholds are formed in DATA_WIDTH+1 bits, so there is no overflow at the extremes.
- eligible = (!order_valid || order_ready) && cooldown == 0 && enable.
- On svm_valid && eligible, the decision d selects the action:
  - FLAT: d ≥ +enter → buy, qty 1, go LONG. d ≤ -enter → sell, qty 1, go SHORT. Otherwise no order.
  - LONG: d ≤ -enter → sell, qty 2, go SHORT (reversal). Else d < +exit → sell, qty 1, go FLAT. Otherwise hold.
  - SHORT: mirror of LONG. d ≥ +enter → buy, qty 2, go LONG. Else d > -exit → buy, qty 1, go FLAT.
- Latency: sample at edge N → order_valid=1 with payload after edge N+1. pos_state/position update at the same edge; update is optimistic, at generation.
- Order generation loads cooldown = COOLDOWN_CYCLES. The counter decrements each cycle while nonzero.
- Handshake: order_valid stays high and the payload stays stable until order_valid && order_ready. Accept and new generation in the same cycle is legal: the register is reloaded with no bubble.
- svm_valid while not eligible: sample ignored, drop_count += 1, saturating at all-ones. A sample that is eligible but yields no order is not a drop.
- Kill switch: while enable=0, pos_state≠FLAT and the order slot is free, generate a flatten order. It is qty 1, side opposite to the position, ignores cooldown and needs no svm_valid. pos_state goes to FLAT and cooldown loads.
- enable=0 in FLAT: nothing is generated; any pending order still drains normally.

Optional Feature:
Macro SVM_PRED_CHECK_EN.
- Defined: a sample is treated as consistent only if svm_pred == (d ≥ 0). An inconsistent but otherwise eligible sample generates no order, increments drop_count and leaves state unchanged.
- Not defined: svm_pred is ignored entirely and no such drop occurs.

Decomposition:
- Package svm_order_pkg: pos_state encodings FLAT/LONG/SHORT, side encodings BUY=1/SELL=0, QTY_SINGLE=1, QTY_REVERSE=2.
- One sub-module, svm_order_slot: a one-entry valid/ready holding register for {side, qty}, with load/accept and synchronous reset.
- State machine, threshold compare, cooldown and drop counter live in the top module.

Test Plan:
Settings for all: enter=0x0080 (0.5), exit=0x0020 (0.125), COOLDOWN_CYCLES=4, order_ready=1 unless stated.
- Entry: FLAT, d=0x0100 → one cycle later order_valid=1, side=1, qty=1; position=+1, pos_state=LONG, cooldown=4.
- Hysteresis: LONG after cooldown. d=0x0040 → no order, drop_count unchanged. d=0x0010 → sell qty 1, FLAT.
- Reversal and cooldown: LONG, d=0xFF00 → sell qty 2, SHORT, position=-1. Second sample 2 cycles later → ignored, drop_count=1.
- Backpressure: order_ready=0 with order pending, 3 samples → drop_count=3, payload stable. Raise ready → exactly one accept.
- Kill switch: SHORT with cooldown active, enable→0 → next cycle buy qty 1, pos_state=FLAT, no svm_valid needed.
- Reset while order_valid=1 and ready=0: after the edge, order_valid=0, position=0, drop_count=0.
